// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register controller.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_e;

  localparam int         CMD_WR_BIT   = 7;
  localparam logic [7:0] IDLE_TX_BYTE = 8'h00;
  localparam int         ERR_CNT_W    = 4;

endpackage

// File: rtl/spi_frame_timeout.sv
// Frame inactivity timer: counts idle cycles while a frame is open and flags
// the last cycle before the frame must be abandoned.
module spi_frame_timeout #(
  parameter int TIMEOUT_CYCLES = 16000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == LAST_CNT);

  // Expiry also restarts from zero so the counter is already clean in IDLE.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || !enable_i || expired_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_reg_controller.sv
// Byte-stream register read/write sequencer behind an SPI byte reader.
// Optional SPI_REG_ERR_CNT_EN adds a saturating protocol error counter to the status read.
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int  NUM_REGS       = 8,
  parameter int  TIMEOUT_CYCLES = 16000,
  localparam int ADDR_W         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  input  logic [7:0]            status_in,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr
);

  localparam logic [ADDR_W-1:0] RO_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          ptr_q, ptr_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]                 tx_q, tx_d;
  logic                       wr_strobe_q, wr_strobe_d;
  logic [NUM_REGS-1:0][7:0]   regs_q;

  logic                       wr_en;
  logic                       rsvd_bad;
  logic                       expired;
  logic [ADDR_W-1:0]          cmd_addr;
  logic [ADDR_W-1:0]          rd_addr;
  logic [7:0]                 rd_byte;
  logic [7:0]                 status_val;

  assign cmd_addr = rx_data[ADDR_W-1:0];
  assign rsvd_bad = |(rx_data[6:0] >> ADDR_W);
  assign rd_addr  = (state_q == IDLE) ? cmd_addr : ptr_q;
  assign rd_byte  = (rd_addr == RO_ADDR) ? status_val : regs_q[rd_addr];
  assign wr_en    = (state_q == WR) && rx_valid && (ptr_q != RO_ADDR);

  spi_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (rx_valid),
    .enable_i (state_q != IDLE),
    .expired_o(expired)
  );

`ifdef SPI_REG_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 unused_status_lo;

  // A write to the status slot is the software handle for clearing the count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == WR) && rx_valid && (ptr_q == RO_ADDR)) begin
      err_cnt_d = '0;
    end else if ((state_q == IDLE) && rx_valid && rsvd_bad && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign status_val       = {status_in[7:4], err_cnt_q};
  assign unused_status_lo = ^status_in[3:0];
`else
  assign status_val = status_in;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    case (state_q)
      IDLE: begin
        if (rx_valid && !rsvd_bad) begin
          if (rx_data[CMD_WR_BIT]) begin
            ptr_d   = cmd_addr;
            state_d = WR;
          end else begin
            tx_d    = rd_byte;
            ptr_d   = cmd_addr + 1'b1;
            state_d = RD;
          end
        end
      end
      WR: begin
        if (rx_valid) begin
          wr_strobe_d = wr_en;
          if (wr_en) begin
            wr_addr_d = ptr_q;
          end
          ptr_d = ptr_q + 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          tx_d    = IDLE_TX_BYTE;
        end
      end
      RD: begin
        if (rx_valid) begin
          tx_d  = rd_byte;
          ptr_d = ptr_q + 1'b1;
        end else if (expired) begin
          state_d = IDLE;
          tx_d    = IDLE_TX_BYTE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      tx_q        <= IDLE_TX_BYTE;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      if (wr_en) begin
        regs_q[ptr_q] <= rx_data;
      end
    end
  end

  // The status slot is never stored, so its window in the flat bus is tied low.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
    if (gi == NUM_REGS - 1) begin : g_ro
      assign regs_flat[8*gi +: 8] = 8'h00;
    end else begin : g_rw
      assign regs_flat[8*gi +: 8] = regs_q[gi];
    end
  end

  assign tx_data   = tx_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_controller.sv
// Scoreboard bench for spi_reg_controller: expected writes and MISO bytes are
// queued as bytes are sent and retired against what the controller produces.
module tb_spi_reg_controller;

  localparam int NUM_REGS = 8;
  localparam int T        = 20;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic [7:0]            status_in;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     wr_addr;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_wr[$];
  logic [15:0] obs_wr[$];
  logic [7:0]  exp_tx[$];

  spi_reg_controller #(
    .NUM_REGS      (NUM_REGS),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .status_in(status_in),
    .regs_flat(regs_flat),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the next negedge, when the update is visible.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (wr_strobe) obs_wr.push_back({5'd0, wr_addr, regs_flat[8*wr_addr +: 8]});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; status_in = 8'h00;
    idle(3);
    rst = 1'b0;
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h want 00", tx_data); end
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b want 0", wr_strobe); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs_flat); end
  endtask

  task automatic test_write;
    logic [15:0] e, o;
    exp_wr.push_back({5'd0, 3'd2, 8'h5A});
    exp_wr.push_back({5'd0, 3'd3, 8'h3C});
    send_byte(8'h82); send_byte(8'h5A); send_byte(8'h3C);
    @(negedge clk);
    checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL write_strobe_width: got %b want 0", wr_strobe); end
    checks++; if (regs_flat[23:16] !== 8'h5A) begin errors++; $display("FAIL write_reg2: got %h want 5a", regs_flat[23:16]); end
    checks++; if (regs_flat[31:24] !== 8'h3C) begin errors++; $display("FAIL write_reg3: got %h want 3c", regs_flat[31:24]); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL write_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL write_event: got %h want %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    idle(T + 1);
  endtask

  task automatic test_read;
    logic [7:0] e;
    exp_tx.push_back(8'h5A); send_byte(8'h02);
    e = exp_tx.pop_front();
    checks++; if (tx_data !== e) begin errors++; $display("FAIL read_first: got %h want %h", tx_data, e); end
    exp_tx.push_back(8'h3C); send_byte(8'hFF);
    e = exp_tx.pop_front();
    checks++; if (tx_data !== e) begin errors++; $display("FAIL read_incr: got %h want %h", tx_data, e); end
    idle(3);
    checks++; if (tx_data !== 8'h3C) begin errors++; $display("FAIL read_hold: got %h want 3c", tx_data); end
    exp_tx.push_back(8'h00); send_byte(8'h00);
    e = exp_tx.pop_front();
    checks++; if (tx_data !== e) begin errors++; $display("FAIL read_reg4: got %h want %h", tx_data, e); end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL read_no_strobe: got %0d want 0", obs_wr.size()); end
    obs_wr.delete();
    idle(T + 1);
  endtask

  task automatic test_wrap;
    logic [15:0] e, o;
    exp_wr.push_back({5'd0, 3'd6, 8'h11});
    exp_wr.push_back({5'd0, 3'd0, 8'h33});
    send_byte(8'h86); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    checks++; if (regs_flat[55:48] !== 8'h11) begin errors++; $display("FAIL wrap_reg6: got %h want 11", regs_flat[55:48]); end
    checks++; if (regs_flat[7:0] !== 8'h33) begin errors++; $display("FAIL wrap_reg0: got %h want 33", regs_flat[7:0]); end
    checks++; if (regs_flat[63:56] !== 8'h00) begin errors++; $display("FAIL wrap_ro_slot: got %h want 00", regs_flat[63:56]); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL wrap_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL wrap_event: got %h want %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    idle(T + 1);
  endtask

  task automatic test_timeout;
    logic [15:0] e, o;
    logic [7:0]  t;
    // Full timeout: the late byte lands in IDLE, where 0x44 has reserved bits set.
    send_byte(8'h81);
    idle(T);
    send_byte(8'h44);
    checks++; if (regs_flat[15:8] !== 8'h00) begin errors++; $display("FAIL timeout_reg1: got %h want 00", regs_flat[15:8]); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL timeout_tx: got %h want 00", tx_data); end
    exp_tx.push_back(8'h5A); send_byte(8'h02);
    t = exp_tx.pop_front();
    checks++; if (tx_data !== t) begin errors++; $display("FAIL timeout_idle_parse: got %h want %h", tx_data, t); end
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL timeout_no_strobe: got %0d want 0", obs_wr.size()); end
    obs_wr.delete();
    idle(T + 1);
    // Byte on the expiry cycle still belongs to the open write frame.
    exp_wr.push_back({5'd0, 3'd1, 8'h44});
    send_byte(8'h81);
    idle(T - 1);
    send_byte(8'h44);
    checks++; if (regs_flat[15:8] !== 8'h44) begin errors++; $display("FAIL expiry_edge_reg1: got %h want 44", regs_flat[15:8]); end
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL expiry_edge_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL expiry_edge_event: got %h want %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
    idle(T + 1);
  endtask

  task automatic test_status;
    logic [7:0] t;
    status_in = 8'hC3;
    send_byte(8'h87); send_byte(8'h87);
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL status_ro_write_strobe: got %0d want 0", obs_wr.size()); end
    obs_wr.delete();
    idle(T + 1);
    send_byte(8'h48);
`ifdef SPI_REG_ERR_CNT_EN
    exp_tx.push_back(8'hC1);
`else
    exp_tx.push_back(8'hC3);
`endif
    send_byte(8'h07);
    status_in = 8'h00;
    idle(2);
    t = exp_tx.pop_front();
    checks++; if (tx_data !== t) begin errors++; $display("FAIL status_read: got %h want %h", tx_data, t); end
    exp_tx.push_back(8'h33); send_byte(8'hA5);
    t = exp_tx.pop_front();
    checks++; if (tx_data !== t) begin errors++; $display("FAIL read_wrap_reg0: got %h want %h", tx_data, t); end
    idle(T + 1);
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL timeout_clears_tx: got %h want 00", tx_data); end
  endtask

  task automatic test_reset_midframe;
    send_byte(8'h80); send_byte(8'h99);
    obs_wr.delete();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL midreset_regs: got %h want 0", regs_flat); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midreset_tx: got %h want 00", tx_data); end
    send_byte(8'h55);
    checks++; if (obs_wr.size() != 0) begin errors++; $display("FAIL midreset_frame_aborted: got %0d strobes want 0", obs_wr.size()); end
    checks++; if (regs_flat !== '0) begin errors++; $display("FAIL midreset_no_write: got %h want 0", regs_flat); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midreset_tx_after: got %h want 00", tx_data); end
    obs_wr.delete();
  endtask

  // Back-to-back bytes in consecutive cycles produce consecutive strobes.
  task automatic test_back_to_back;
    logic [15:0] e, o;
    idle(T + 1);
    exp_wr.push_back({5'd0, 3'd4, 8'hA1});
    exp_wr.push_back({5'd0, 3'd5, 8'hB2});
    exp_wr.push_back({5'd0, 3'd6, 8'hC3});
    send_byte(8'h84); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    checks++; if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_event: got %h want %h", o, e); end
    end
    exp_wr.delete(); obs_wr.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_timeout();
    test_status();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
